// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter in front of the single-port word data memory.
// Sub-word stores become a read-modify-write because the memory only writes whole words.
module dm_arbiter #(
  parameter int DM_SIZE    = 3072,
  parameter bit FIRST_PORT = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [31:0] a_addr,
  input  logic [3:0]  a_be,
  input  logic [31:0] a_wdata,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [31:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [31:0] b_addr,
  input  logic [3:0]  b_be,
  input  logic [31:0] b_wdata,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [31:0] b_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] ADDR_LIM = 32'(DM_SIZE) * 32'd4;

  typedef enum logic [1:0] {IDLE, RMW_RD, RMW_WR} state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  state_t      state;
  req_t        ra, rb, win;
  logic        last_b, own_b, sel_b, any_req;
  logic        win_oor, win_full, win_part;
  logic        gnt_any, gnt_b;
  logic [29:0] lat_addr;
  logic [3:0]  lat_be;
  logic [31:0] lat_wdata, old_word, merged;

  assign ra = {a_we, a_addr, a_be, a_wdata};
  assign rb = {b_we, b_addr, b_be, b_wdata};

  // B wins when alone, or on a tie when A was granted most recently.
  assign sel_b    = b_req && (!a_req || !last_b);
  assign any_req  = a_req || b_req;
  assign win      = sel_b ? rb : ra;
  assign win_oor  = win.addr >= ADDR_LIM;
  assign win_full = win.we && !win_oor && (win.be == 4'hF);
  assign win_part = win.we && !win_oor && (win.be != 4'h0) && (win.be != 4'hF);

  for (genvar i = 0; i < 4; i++) begin : g_merge
    assign merged[8*i +: 8] = lat_be[i] ? lat_wdata[8*i +: 8] : old_word[8*i +: 8];
  end

  // Nothing reaches the memory or the ports while reset is held, so an
  // abort in the middle of a read-modify-write never writes or grants.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    gnt_any   = 1'b0;
    gnt_b     = 1'b0;
    if (reset) begin
      case (state)
        IDLE: if (any_req) begin
          mem_addr = {win.addr[31:2], 2'b00};
          if (!win_part) begin
            gnt_any = 1'b1;
            gnt_b   = sel_b;
          end
          if (win_full) begin
            mem_we    = 1'b1;
            mem_wdata = win.wdata;
          end
        end
        RMW_RD: mem_addr = {lat_addr, 2'b00};
        RMW_WR: begin
          mem_addr  = {lat_addr, 2'b00};
          mem_we    = 1'b1;
          mem_wdata = merged;
          gnt_any   = 1'b1;
          gnt_b     = own_b;
        end
        default: ;
      endcase
    end
  end

  assign a_gnt = gnt_any && !gnt_b;
  assign b_gnt = gnt_any && gnt_b;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      last_b    <= !FIRST_PORT;
      own_b     <= 1'b0;
      lat_addr  <= '0;
      lat_be    <= '0;
      lat_wdata <= '0;
      old_word  <= '0;
      a_rdata   <= '0;
      b_rdata   <= '0;
      a_rvalid  <= 1'b0;
      b_rvalid  <= 1'b0;
    end else begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      if (gnt_any) last_b <= gnt_b;
      case (state)
        IDLE: if (any_req) begin
          if (win_part) begin
            own_b     <= sel_b;
            lat_addr  <= win.addr[31:2];
            lat_be    <= win.be;
            lat_wdata <= win.wdata;
            state     <= RMW_RD;
          end else if (!win.we) begin
            if (sel_b) begin
              b_rdata  <= win_oor ? 32'h0 : mem_rdata;
              b_rvalid <= 1'b1;
            end else begin
              a_rdata  <= win_oor ? 32'h0 : mem_rdata;
              a_rvalid <= 1'b1;
            end
          end
        end
        RMW_RD: begin
          old_word <= mem_rdata;
          state    <= RMW_WR;
        end
        RMW_WR:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural word memory on the mem_* side.
module tb_dm_arbiter;
  localparam int DM_SIZE = 3072;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [31:0] a_addr = 0, a_wdata = 0, b_addr = 0, b_wdata = 0;
  logic [3:0]  a_be = 0, b_be = 0;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid, mem_we;
  logic [31:0] a_rdata, b_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] tbmem [DM_SIZE];
  int n_pass = 0, n_total = 0;

  dm_arbiter #(.DM_SIZE(DM_SIZE), .FIRST_PORT(1'b0)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_be(a_be), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_be(b_be), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Out-of-range reads return garbage so the DUT must force zero itself.
  assign mem_rdata = (mem_addr[31:2] < DM_SIZE) ? tbmem[mem_addr[13:2]] : 32'hBAD0BAD0;
  always @(posedge clk)
    if (mem_we && mem_addr[31:2] < DM_SIZE) tbmem[mem_addr[13:2]] <= mem_wdata;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++; if ({a_gnt, b_gnt, a_rvalid, b_rvalid, mem_we} !== 5'b0) $display("FAIL reset_ctl: got %b want 00000", {a_gnt, b_gnt, a_rvalid, b_rvalid, mem_we}); else n_pass++;
    n_total++; if (a_rdata !== 32'h0 || b_rdata !== 32'h0) $display("FAIL reset_rdata: got %h %h want 0 0", a_rdata, b_rdata); else n_pass++;
    n_total++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) $display("FAIL reset_mem: got %h %h want 0 0", mem_addr, mem_wdata); else n_pass++;
    n_total++; if (dut.state !== 2'd0) $display("FAIL reset_state: got %0d want 0", dut.state); else n_pass++;
    tick(); reset = 1'b1;
  endtask

  task automatic test_read();
    tbmem[4] <= 32'hDEADBEEF;
    a_req = 1; a_we = 0; a_addr = 32'h10; a_be = 4'hF;
    @(negedge clk);
    n_total++; if ({a_gnt, b_gnt, mem_we} !== 3'b100) $display("FAIL read_gnt: got %b want 100", {a_gnt, b_gnt, mem_we}); else n_pass++;
    n_total++; if (mem_addr !== 32'h10) $display("FAIL read_addr: got %h want 00000010", mem_addr); else n_pass++;
    tick(); a_req = 0;
    @(negedge clk);
    n_total++; if ({a_rvalid, a_gnt} !== 2'b10) $display("FAIL read_rvalid: got %b want 10", {a_rvalid, a_gnt}); else n_pass++;
    n_total++; if (a_rdata !== 32'hDEADBEEF) $display("FAIL read_data: got %h want deadbeef", a_rdata); else n_pass++;
    tick();
    @(negedge clk);
    n_total++; if (a_rvalid !== 1'b0 || a_rdata !== 32'hDEADBEEF) $display("FAIL read_hold: got %b %h want 0 deadbeef", a_rvalid, a_rdata); else n_pass++;
    tick();
  endtask

  // Last grant was A, so B's partial write wins the tie and A stalls behind the RMW.
  task automatic test_rmw();
    tbmem[16] <= 32'hAABBCCDD;
    tbmem[5]  <= 32'h13572468;
    b_req = 1; b_we = 1; b_addr = 32'h40; b_be = 4'b0110; b_wdata = 32'h11223344;
    a_req = 1; a_we = 0; a_addr = 32'h14; a_be = 4'hF;
    @(negedge clk);
    n_total++; if ({a_gnt, b_gnt, mem_we} !== 3'b000) $display("FAIL rmw_c0: got %b want 000", {a_gnt, b_gnt, mem_we}); else n_pass++;
    tick(); @(negedge clk);
    n_total++; if ({a_gnt, b_gnt, mem_we} !== 3'b000 || mem_addr !== 32'h40) $display("FAIL rmw_c1: got %b %h want 000 00000040", {a_gnt, b_gnt, mem_we}, mem_addr); else n_pass++;
    tick(); @(negedge clk);
    n_total++; if ({a_gnt, b_gnt, mem_we} !== 3'b011) $display("FAIL rmw_c2: got %b want 011", {a_gnt, b_gnt, mem_we}); else n_pass++;
    n_total++; if (mem_wdata !== 32'hAA2233DD) $display("FAIL rmw_merge: got %h want aa2233dd", mem_wdata); else n_pass++;
    tick(); b_req = 0;
    @(negedge clk);
    n_total++; if ({a_gnt, b_gnt} !== 2'b10) $display("FAIL rmw_c3_a: got %b want 10", {a_gnt, b_gnt}); else n_pass++;
    n_total++; if (tbmem[16] !== 32'hAA2233DD) $display("FAIL rmw_word: got %h want aa2233dd", tbmem[16]); else n_pass++;
    tick(); a_req = 0;
    @(negedge clk);
    n_total++; if (a_rvalid !== 1'b1 || a_rdata !== 32'h13572468) $display("FAIL rmw_a_read: got %b %h want 1 13572468", a_rvalid, a_rdata); else n_pass++;
    tick();
  endtask

  task automatic test_alternate();
    reset = 0; tick(); reset = 1;
    a_req = 1; a_we = 1; a_addr = 32'h20; a_be = 4'hF; a_wdata = 32'hA5A5A5A5;
    b_req = 1; b_we = 1; b_addr = 32'h24; b_be = 4'hF; b_wdata = 32'h5A5A5A5A;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_total++;
      if ((i % 2) == 0) begin
        if ({a_gnt, b_gnt, mem_we} !== 3'b101 || mem_wdata !== 32'hA5A5A5A5 || mem_addr !== 32'h20)
          $display("FAIL alt_%0d: got %b %h %h want 101 a5a5a5a5 00000020", i, {a_gnt, b_gnt, mem_we}, mem_wdata, mem_addr);
        else n_pass++;
      end else begin
        if ({a_gnt, b_gnt, mem_we} !== 3'b011 || mem_wdata !== 32'h5A5A5A5A || mem_addr !== 32'h24)
          $display("FAIL alt_%0d: got %b %h %h want 011 5a5a5a5a 00000024", i, {a_gnt, b_gnt, mem_we}, mem_wdata, mem_addr);
        else n_pass++;
      end
      tick();
    end
    a_req = 0; b_req = 0;
    @(negedge clk);
    n_total++; if (tbmem[8] !== 32'hA5A5A5A5 || tbmem[9] !== 32'h5A5A5A5A) $display("FAIL alt_mem: got %h %h want a5a5a5a5 5a5a5a5a", tbmem[8], tbmem[9]); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid_rmw();
    tbmem[20] <= 32'h55667788;
    a_req = 1; a_we = 1; a_addr = 32'h50; a_be = 4'b0001; a_wdata = 32'h000000FF;
    @(negedge clk);
    n_total++; if ({a_gnt, mem_we} !== 2'b00) $display("FAIL abort_c0: got %b want 00", {a_gnt, mem_we}); else n_pass++;
    tick(); reset = 0;
    @(negedge clk);
    n_total++; if ({a_gnt, b_gnt, mem_we} !== 3'b000) $display("FAIL abort_rd: got %b want 000", {a_gnt, b_gnt, mem_we}); else n_pass++;
    tick(); a_req = 0; reset = 1;
    @(negedge clk);
    n_total++; if (dut.state !== 2'd0 || {a_gnt, mem_we} !== 2'b00) $display("FAIL abort_idle: got %0d %b want 0 00", dut.state, {a_gnt, mem_we}); else n_pass++;
    n_total++; if (tbmem[20] !== 32'h55667788) $display("FAIL abort_word: got %h want 55667788", tbmem[20]); else n_pass++;
    tick();
  endtask

  task automatic test_oor();
    a_req = 1; a_we = 0; a_addr = 32'h10; a_be = 4'hF;
    @(negedge clk);
    n_total++; if (a_gnt !== 1'b1) $display("FAIL oor_pre_gnt: got %b want 1", a_gnt); else n_pass++;
    tick(); a_we = 1; a_addr = DM_SIZE * 4 - 4; a_wdata = 32'hCAFEF00D;
    @(negedge clk);
    n_total++; if (a_rvalid !== 1'b1 || a_rdata !== 32'hDEADBEEF) $display("FAIL oor_pre_data: got %b %h want 1 deadbeef", a_rvalid, a_rdata); else n_pass++;
    n_total++; if ({a_gnt, mem_we} !== 2'b11) $display("FAIL last_word_we: got %b want 11", {a_gnt, mem_we}); else n_pass++;
    tick(); a_addr = DM_SIZE * 4; a_be = 4'b0110; a_wdata = 32'h12345678;
    @(negedge clk);
    n_total++; if ({a_gnt, mem_we} !== 2'b10) $display("FAIL oor_write: got %b want 10", {a_gnt, mem_we}); else n_pass++;
    tick(); a_we = 0; a_be = 4'hF;
    @(negedge clk);
    n_total++; if ({a_gnt, mem_we} !== 2'b10) $display("FAIL oor_read_gnt: got %b want 10", {a_gnt, mem_we}); else n_pass++;
    tick(); a_req = 0;
    @(negedge clk);
    n_total++; if (a_rvalid !== 1'b1 || a_rdata !== 32'h0) $display("FAIL oor_read_data: got %b %h want 1 00000000", a_rvalid, a_rdata); else n_pass++;
    n_total++; if (tbmem[DM_SIZE-1] !== 32'hCAFEF00D) $display("FAIL last_word: got %h want cafef00d", tbmem[DM_SIZE-1]); else n_pass++;
    tick();
  endtask

  task automatic test_null_write();
    tbmem[24] <= 32'h0F0F0F0F;
    b_req = 1; b_we = 1; b_addr = 32'h60; b_be = 4'h0; b_wdata = 32'hFFFFFFFF;
    @(negedge clk);
    n_total++; if ({a_gnt, b_gnt, mem_we} !== 3'b010) $display("FAIL null_write: got %b want 010", {a_gnt, b_gnt, mem_we}); else n_pass++;
    tick(); b_req = 0;
    @(negedge clk);
    n_total++; if (dut.state !== 2'd0 || b_gnt !== 1'b0 || tbmem[24] !== 32'h0F0F0F0F) $display("FAIL null_after: got %0d %b %h want 0 0 0f0f0f0f", dut.state, b_gnt, tbmem[24]); else n_pass++;
    tick();
  endtask

  initial begin
    for (int i = 0; i < DM_SIZE; i++) tbmem[i] <= 32'h0;
    #1;
    test_reset();
    test_read();
    test_rmw();
    test_alternate();
    test_reset_mid_rmw();
    test_oor();
    test_null_write();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port word data memory.
- Port A is the pipeline MEM stage; port B is the debug/DMA loader.
- Shares the memory round-robin between the two ports, registers read data, and turns sub-word stores into a read-modify-write sequence, since the memory writes whole words only.
- The memory is word-addressed by addr>>2, has an asynchronous read, and a write that takes effect at posedge clk.

Parameters:
- DM_SIZE, 3072: memory depth in 32-bit words. Byte addresses at or above DM_SIZE*4 are out of range.
- FIRST_PORT, 0: port favoured at the first arbitration after reset. 0 = A, 1 = B.

Ports:
- clk, input, 1: single clock. All state changes on posedge.
- reset, input, 1: synchronous, active-low reset.
- a_req, input, 1: port A request. Held high with fields stable until a_gnt.
- a_we, input, 1: port A write (1) or read (0).
- a_addr, input, 32: port A byte address. Bits [1:0] are ignored.
- a_be, input, 4: port A byte enables. Bit i selects bits [8i+7:8i].
- a_wdata, input, 32: port A write data, byte-lane aligned.
- a_gnt, output, 1: one-cycle pulse when the port A access completes or is accepted.
- a_rvalid, output, 1: one-cycle pulse, exactly one cycle after a read grant.
- a_rdata, output, 32: registered read data. Holds its value until the next port A read.
- b_req, b_we, b_addr, b_be, b_wdata, b_gnt, b_rvalid, b_rdata: identical set for port B.
- mem_addr, output, 32: word-aligned byte address to the memory, {addr[31:2], 2'b00}.
- mem_wdata, output, 32: write data to the memory.
- mem_we, output, 1: memory write enable.
- mem_rdata, input, 32: asynchronous read data from the memory.

Behaviour:
- Reset values (reset=0 at posedge):
  - state=IDLE.
  - a_gnt, b_gnt, a_rvalid, b_rvalid, mem_we = 0.
  - a_rdata, b_rdata, mem_addr, mem_wdata = 0.
  - last-grant pointer set so that FIRST_PORT wins the first tie.
- Reset asserted mid-RMW: abort the sequence, no memory write occurs, no grant is issued, return to IDLE.
- Outputs are combinational from state and latched fields. rdata, rvalid and the RMW latches are registered.
- Arbitration (IDLE only):
  - Only one port requesting: that port wins.
  - Both requesting: the port not granted most recently wins.
  - The pointer updates on every grant.
  - No request: mem_we=0, mem_addr=0.
- Read (we=0), handled in the IDLE cycle:
  - mem_addr is driven from the winner and the winner's gnt pulses.
  - mem_rdata is captured into the winner's rdata at the same edge; rvalid pulses in the next cycle.
  - Latency from grant to rvalid is 1 cycle.
  - Back-to-back reads sustain 1 access per cycle.
- Full write (we=1, be=4'hF): mem_we=1 and mem_wdata=wdata in the IDLE cycle, gnt pulses the same cycle. Latency 1 cycle.
- Null write (we=1, be=4'h0): granted in IDLE, mem_we stays 0.
- Partial write (we=1, be not 0 and not F):
  - IDLE: latch owner, addr, be, wdata. Go to RMW_RD. No gnt.
  - RMW_RD: mem_addr = latched address, mem_we=0. Latch mem_rdata as the old word. Go to RMW_WR.
  - RMW_WR: mem_we=1; mem_wdata = per-byte be ? wdata byte : old byte. Owner's gnt pulses. Go to IDLE.
  - Total occupancy is 3 cycles. The other port is stalled throughout; its request stays pending.
  - The losing port's request is not dropped and wins the next IDLE arbitration.
- Out of range (addr >= DM_SIZE*4):
  - Granted in IDLE in 1 cycle regardless of be.
  - mem_we stays 0. No RMW is started.
  - A read returns rdata=0 with a normal rvalid.
- A gnt is never asserted for both ports in the same cycle. The memory sees at most one write per cycle.
- Request dropped before gnt is a protocol violation. Behaviour is undefined, but the block must return to IDLE within 3 cycles.

Test Plan:
- Reset (reset=0 for 2 cycles) then both ports idle -> every output is 0 and state=IDLE.
- a_req read 0x10 with memory word 4 = 0xDEADBEEF -> a_gnt in cycle 0; a_rvalid in cycle 1 with a_rdata=0xDEADBEEF.
- a_req and b_req both full writes, held continuously, FIRST_PORT=0 -> grants alternate A,B,A,B. Memory is written with the matching wdata each cycle.
- Port B partial write, be=4'b0110, wdata=0x11223344, at word 0xAABBCCDD, while A requests a read -> after 3 cycles the word is 0xAA2233DD. b_gnt pulses in cycle 2. a_gnt comes in cycle 3.
- Reset asserted in the RMW_RD cycle of a partial write -> mem_we never pulses, the word is unchanged, no gnt, state=IDLE.
- a_addr = DM_SIZE*4 write then read -> mem_we stays 0; read returns a_rdata=0 with a_rvalid.
